// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port among three clients.
//   Port 0 = ioctl/SPI download, port 1 = video fetch, port 2 = CPU bus.
//   Fixed priority p0 > p1 > p2. A CPU starvation counter boosts p2 to
//   the top once it has waited CPU_MAX_WAIT cycles.
// Ports:
//   CLK, RESET        single clock, synchronous active-high reset
//   p{n}_req/we/addr/din/be  requester side, level req held until ack
//   p{n}_ack/dout     one-cycle completion pulse, read data held until next ack
//   mem_*             controller side, level req / one-cycle mem_ack
//   owner             granted port, 3 = none
// All outputs are registered.
module sdram_port_arbiter #(
  parameter int unsigned AW           = 24,
  parameter int unsigned CPU_MAX_WAIT = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [15:0]   p0_din,
  input  logic [1:0]    p0_be,
  output logic          p0_ack,
  output logic [15:0]   p0_dout,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [15:0]   p1_din,
  input  logic [1:0]    p1_be,
  output logic          p1_ack,
  output logic [15:0]   p1_dout,
  input  logic          p2_req,
  input  logic          p2_we,
  input  logic [AW-1:0] p2_addr,
  input  logic [15:0]   p2_din,
  input  logic [1:0]    p2_be,
  output logic          p2_ack,
  output logic [15:0]   p2_dout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  input  logic          mem_ack,
  input  logic [15:0]   mem_dout,
  output logic [1:0]    owner
);

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned OW = 2;

  localparam logic [OW-1:0] OWNER_NONE = OW'(3);
  localparam logic [OW-1:0] OWNER_CPU  = OW'(2);
  localparam logic [CW-1:0] WAIT_SAT   = '1;
  localparam logic [CW-1:0] BOOST_AT   = CW'(CPU_MAX_WAIT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NP-1:0]         req_v, we_v;
  logic [NP-1:0][AW-1:0] addr_v;
  logic [NP-1:0][DW-1:0] din_v;
  logic [NP-1:0][BW-1:0] be_v;

  logic [NP-1:0]         elig;
  logic                  boost;
  logic                  grant_vld;
  logic [OW-1:0]         grant_sel;

  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_din_q, mem_din_d;
  logic [BW-1:0]         mem_be_q, mem_be_d;
  logic [NP-1:0]         ack_q, ack_d;
  logic [NP-1:0][DW-1:0] dout_q, dout_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [CW-1:0]         cpu_wait_q, cpu_wait_d;

  // Gather per-port requester fields into indexable vectors
  assign req_v  = {p2_req, p1_req, p0_req};
  assign we_v   = {p2_we, p1_we, p0_we};
  assign addr_v = {p2_addr, p1_addr, p0_addr};
  assign din_v  = {p2_din, p1_din, p0_din};
  assign be_v   = {p2_be, p1_be, p0_be};

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Arbitration and next state; a port whose ack is high this cycle is
  // masked because its req has not dropped yet
  always_comb begin
    elig      = req_v & ~ack_q;
    boost     = (cpu_wait_q >= BOOST_AT);
    grant_vld = |elig;
    grant_sel = OWNER_NONE;
    if (boost && elig[2])  grant_sel = OW'(2);
    else if (elig[0])      grant_sel = OW'(0);
    else if (elig[1])      grant_sel = OW'(1);
    else if (elig[2])      grant_sel = OW'(2);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_vld) state_d = ST_BUSY;
      ST_BUSY: if (mem_ack)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_be_d   = mem_be_q;
    ack_d      = '0;
    dout_d     = dout_q;
    owner_d    = owner_q;
    cpu_wait_d = cpu_wait_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          mem_req_d  = 1'b1;
          mem_we_d   = we_v[grant_sel];
          mem_addr_d = addr_v[grant_sel];
          mem_din_d  = din_v[grant_sel];
          mem_be_d   = be_v[grant_sel];
          owner_d    = grant_sel;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          owner_d   = OWNER_NONE;
          for (int i = 0; i < NP; i++) begin
            if (owner_q == OW'(i)) begin
              ack_d[i]  = 1'b1;
              dout_d[i] = mem_dout;
            end
          end
        end
      end
      default: ;
    endcase

    // CPU starvation counter: clears on grant or idle CPU, saturates
    if (!p2_req) begin
      cpu_wait_d = '0;
    end else if ((state_q == ST_IDLE) && grant_vld && (grant_sel == OWNER_CPU)) begin
      cpu_wait_d = '0;
    end else if ((owner_q != OWNER_CPU) && (cpu_wait_q != WAIT_SAT)) begin
      cpu_wait_d = cpu_wait_q + CW'(1);
    end
  end

  // Output and counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= '0;
      ack_q      <= '0;
      dout_q     <= '0;
      owner_q    <= OWNER_NONE;
      cpu_wait_q <= '0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_be_q   <= mem_be_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      owner_q    <= owner_d;
      cpu_wait_q <= cpu_wait_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_be   = mem_be_q;
  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p2_ack   = ack_q[2];
  assign p0_dout  = dout_q[0];
  assign p1_dout  = dout_q[1];
  assign p2_dout  = dout_q[2];
  assign owner    = owner_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 24;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [15:0]   p0_din = '0;
  logic [1:0]    p0_be = '0;
  logic          p0_ack;
  logic [15:0]   p0_dout;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [15:0]   p1_din = '0;
  logic [1:0]    p1_be = '0;
  logic          p1_ack;
  logic [15:0]   p1_dout;
  logic          p2_req = 1'b0, p2_we = 1'b0;
  logic [AW-1:0] p2_addr = '0;
  logic [15:0]   p2_din = '0;
  logic [1:0]    p2_be = '0;
  logic          p2_ack;
  logic [15:0]   p2_dout;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_dout = '0;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;

  logic [2:0]    acks;
  assign acks = {p2_ack, p1_ack, p0_ack};

  sdram_port_arbiter #(.AW(AW), .CPU_MAX_WAIT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_dout(p1_dout),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din), .p2_be(p2_be),
    .p2_ack(p2_ack), .p2_dout(p2_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_dout(mem_dout), .owner(owner)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
    checks++; if ({mem_we, mem_be, mem_din} !== 19'h0) begin errors++; $display("FAIL rst_mem_misc: got %b/%b/%h exp 0", mem_we, mem_be, mem_din); end
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rst_acks: got %b exp 000", acks); end
    checks++; if ({p0_dout, p1_dout, p2_dout} !== 48'h0) begin errors++; $display("FAIL rst_dout: got %h %h %h exp 0", p0_dout, p1_dout, p2_dout); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL rst_owner: got %0d exp 3", owner); end
    checks++; if (dut.cpu_wait_q !== 8'd0) begin errors++; $display("FAIL rst_cpu_wait: got %0d exp 0", dut.cpu_wait_q); end
  endtask

  task automatic test_single_read();
    @(negedge CLK);
    p1_addr = 24'h001234; p1_we = 1'b0; p1_be = 2'b11; p1_req = 1'b1;
    @(negedge CLK);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sr_mem_req: got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 24'h001234) begin errors++; $display("FAIL sr_mem_addr: got %h exp 001234", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sr_mem_we: got %b exp 0", mem_we); end
    checks++; if (owner !== 2'd1) begin errors++; $display("FAIL sr_owner: got %0d exp 1", owner); end
    repeat (4) begin
      @(negedge CLK);
      checks++; if ({mem_req, p1_ack} !== 2'b10) begin errors++; $display("FAIL sr_wait: got req=%b ack=%b exp req=1 ack=0", mem_req, p1_ack); end
    end
    mem_ack = 1'b1; mem_dout = 16'hBEEF;
    @(negedge CLK);
    mem_ack = 1'b0; mem_dout = 16'h0;
    checks++; if (acks !== 3'b010) begin errors++; $display("FAIL sr_ack: got %b exp 010", acks); end
    checks++; if (p1_dout !== 16'hBEEF) begin errors++; $display("FAIL sr_dout: got %h exp BEEF", p1_dout); end
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL sr_release: got req=%b owner=%0d exp req=0 owner=3", mem_req, owner); end
    p1_req = 1'b0;
    @(negedge CLK);
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL sr_ack_pulse: got %b exp 000", acks); end
    checks++; if (p1_dout !== 16'hBEEF) begin errors++; $display("FAIL sr_dout_hold: got %h exp BEEF", p1_dout); end
  endtask

  task automatic test_simultaneous();
    logic [23:0] exp_addr [3];
    logic [15:0] rd_data [3];
    exp_addr[0] = 24'h000010; exp_addr[1] = 24'h000020; exp_addr[2] = 24'h000030;
    rd_data[0] = 16'h1111; rd_data[1] = 16'h2222; rd_data[2] = 16'h3333;
    @(negedge CLK);
    p0_addr = 24'h000010; p0_we = 1'b1; p0_din = 16'hA5A5; p0_be = 2'b01; p0_req = 1'b1;
    p1_addr = 24'h000020; p1_we = 1'b0; p1_be = 2'b11; p1_req = 1'b1;
    p2_addr = 24'h000030; p2_we = 1'b0; p2_be = 2'b11; p2_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge CLK);
      checks++; if ({mem_req, owner} !== {1'b1, 2'(g)}) begin errors++; $display("FAIL sim_grant%0d: got req=%b owner=%0d exp req=1 owner=%0d", g, mem_req, owner, g); end
      checks++; if (mem_addr !== exp_addr[g]) begin errors++; $display("FAIL sim_addr%0d: got %h exp %h", g, mem_addr, exp_addr[g]); end
      checks++; if (mem_we !== (g == 0)) begin errors++; $display("FAIL sim_we%0d: got %b exp %b", g, mem_we, (g == 0)); end
      checks++; if (acks !== 3'b000) begin errors++; $display("FAIL sim_dup%0d: got %b exp 000", g, acks); end
      if (g == 0) begin
        checks++; if ({mem_be, mem_din} !== {2'b01, 16'hA5A5}) begin errors++; $display("FAIL sim_p0_be_din: got %b/%h exp 01/A5A5", mem_be, mem_din); end
      end
      @(negedge CLK);
      @(negedge CLK);
      mem_ack = 1'b1; mem_dout = rd_data[g];
      @(negedge CLK);
      mem_ack = 1'b0; mem_dout = 16'h0;
      checks++; if (acks !== (3'b001 << g)) begin errors++; $display("FAIL sim_ack%0d: got %b exp %b", g, acks, (3'b001 << g)); end
      if (g == 0) p0_req = 1'b0;
      if (g == 1) p1_req = 1'b0;
      if (g == 2) p2_req = 1'b0;
    end
    checks++; if ({p0_dout, p1_dout, p2_dout} !== 48'h1111_2222_3333) begin errors++; $display("FAIL sim_dout: got %h %h %h exp 1111 2222 3333", p0_dout, p1_dout, p2_dout); end
    @(negedge CLK);
    checks++; if ({mem_req, acks} !== 4'b0000) begin errors++; $display("FAIL sim_quiet: got req=%b acks=%b exp 0/000", mem_req, acks); end
  endtask

  task automatic test_stray_ack();
    @(negedge CLK);
    mem_ack = 1'b1; mem_dout = 16'hDEAD;
    @(negedge CLK);
    mem_ack = 1'b0; mem_dout = 16'h0;
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL stray_acks: got %b exp 000", acks); end
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL stray_idle: got req=%b owner=%0d exp 0/3", mem_req, owner); end
    checks++; if ({p0_dout, p1_dout, p2_dout} !== 48'h1111_2222_3333) begin errors++; $display("FAIL stray_dout: got %h %h %h exp 1111 2222 3333", p0_dout, p1_dout, p2_dout); end
    @(negedge CLK);
    checks++; if ({mem_req, acks} !== 4'b0000) begin errors++; $display("FAIL stray_after: got req=%b acks=%b exp 0/000", mem_req, acks); end
  endtask

  // p0 and p1 hammer continuously; without the guard p2 would never win
  task automatic test_starvation();
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd1; order[4] = 2'd2;
    @(negedge CLK);
    p0_addr = 24'h000100; p0_we = 1'b0; p0_req = 1'b1;
    p1_addr = 24'h000200; p1_we = 1'b0; p1_req = 1'b1;
    p2_addr = 24'h000300; p2_we = 1'b0; p2_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(negedge CLK);
      checks++; if ({mem_req, owner} !== {1'b1, order[g]}) begin errors++; $display("FAIL starve_grant%0d: got req=%b owner=%0d exp req=1 owner=%0d", g, mem_req, owner, order[g]); end
      if (g == 4) begin
        checks++; if (dut.cpu_wait_q !== 8'd0) begin errors++; $display("FAIL starve_clear: got %0d exp 0", dut.cpu_wait_q); end
      end
      mem_ack = 1'b1; mem_dout = 16'h4000 + 16'(g);
      @(negedge CLK);
      mem_ack = 1'b0;
      checks++; if (acks !== (3'b001 << order[g])) begin errors++; $display("FAIL starve_ack%0d: got %b exp %b", g, acks, (3'b001 << order[g])); end
      if (g == 3) begin
        checks++; if (dut.cpu_wait_q !== 8'd8) begin errors++; $display("FAIL starve_wait: got %0d exp 8", dut.cpu_wait_q); end
      end
    end
    checks++; if (p2_dout !== 16'h4004) begin errors++; $display("FAIL starve_p2_dout: got %h exp 4004", p2_dout); end
    p0_req = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
    @(negedge CLK);
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL starve_end: got req=%b owner=%0d exp 0/3", mem_req, owner); end
  endtask

  task automatic test_ack_mask();
    @(negedge CLK);
    p0_addr = 24'h000040; p0_we = 1'b0; p0_req = 1'b1;
    @(negedge CLK);
    checks++; if ({mem_req, owner} !== 3'b100) begin errors++; $display("FAIL mask_grant: got req=%b owner=%0d exp 1/0", mem_req, owner); end
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    checks++; if (acks !== 3'b001) begin errors++; $display("FAIL mask_ack: got %b exp 001", acks); end
    @(negedge CLK);
    checks++; if ({mem_req, owner, acks} !== 6'b011000) begin errors++; $display("FAIL mask_no_regrant: got req=%b owner=%0d acks=%b exp 0/3/000", mem_req, owner, acks); end
    p0_req = 1'b0;
    @(negedge CLK);
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL mask_idle: got req=%b owner=%0d exp 0/3", mem_req, owner); end
    p0_req = 1'b1;
    @(negedge CLK);
    checks++; if ({mem_req, owner} !== 3'b100) begin errors++; $display("FAIL mask_rereq: got req=%b owner=%0d exp 1/0", mem_req, owner); end
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0; p0_req = 1'b0;
    checks++; if (acks !== 3'b001) begin errors++; $display("FAIL mask_ack2: got %b exp 001", acks); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    p1_addr = 24'h000050; p1_we = 1'b1; p1_din = 16'h5A5A; p1_be = 2'b10; p1_req = 1'b1;
    @(negedge CLK);
    checks++; if ({mem_req, owner} !== 3'b101) begin errors++; $display("FAIL rm_busy: got req=%b owner=%0d exp 1/1", mem_req, owner); end
    RESET = 1'b1; p1_req = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL rm_release: got req=%b owner=%0d exp 0/3", mem_req, owner); end
    checks++; if ({mem_we, mem_addr, mem_din, mem_be} !== 43'h0) begin errors++; $display("FAIL rm_mem_fields: got %b/%h/%h/%b exp 0", mem_we, mem_addr, mem_din, mem_be); end
    checks++; if ({p0_dout, p1_dout, p2_dout} !== 48'h0) begin errors++; $display("FAIL rm_dout: got %h %h %h exp 0", p0_dout, p1_dout, p2_dout); end
    mem_ack = 1'b1; mem_dout = 16'hFACE;
    @(negedge CLK);
    mem_ack = 1'b0; mem_dout = 16'h0;
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rm_stale_ack: got %b exp 000", acks); end
    checks++; if ({p0_dout, p1_dout, p2_dout} !== 48'h0) begin errors++; $display("FAIL rm_stale_dout: got %h %h %h exp 0", p0_dout, p1_dout, p2_dout); end
    checks++; if ({mem_req, owner} !== 3'b011) begin errors++; $display("FAIL rm_stale_idle: got req=%b owner=%0d exp 0/3", mem_req, owner); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_stray_ack();
    test_starvation();
    test_ack_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
